// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC pulse meter.
package tdc_pkg;

  typedef enum logic [2:0] {
    IDLE, COUNT, LATCH, SEND, GUARD1, GUARD2, WAIT_EOT
  } state_t;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;
  localparam int STAT_SAT    = 0;
  localparam int STAT_MISSED = 1;

endpackage

// File: rtl/tdc_sat_counter.sv
// Saturating up-counter: load1 restarts at 1, en counts up; sat sticks once all-ones is reached.
module tdc_sat_counter
  import tdc_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load1,
  input  logic             en,
  output logic [WIDTH-1:0] count,
  output logic             sat
);

  localparam logic [WIDTH-1:0] MAXV = '1;

  logic [WIDTH-1:0] nxt;
  assign nxt = count + WIDTH'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
      sat   <= 1'b0;
    end else if (load1) begin
      count <= WIDTH'(1);
      sat   <= 1'b0;
    end else if (en && count != MAXV) begin
      count <= nxt;
      if (nxt == MAXV) sat <= 1'b1;
    end
  end

endmodule

// File: rtl/tdc_pulse_meter.sv
// Measures the high time of stop in clk cycles, then ships header/status/count bytes
// through the byte-wide transmitter handshake.
module tdc_pulse_meter
  import tdc_pkg::*;
#(
  parameter int         CNT_W       = 16,   // multiple of 8, 8..32
  parameter bit         SEND_HEADER = 1'b1,
  parameter logic [7:0] HEADER      = HEADER_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stop,
  output logic [7:0]       tx_data,
  output logic             tx_stt,
  input  logic             tx_eot,
  output logic             busy,
  output logic             overflow,
  output logic [CNT_W-1:0] last_count
);

  localparam int NBYTES  = CNT_W / 8;
  localparam int HDR     = SEND_HEADER ? 1 : 0;
  localparam int FRAME_N = NBYTES + 1 + HDR;

  state_t           state, next;
  logic             sync1, s_q, s_prev, rise;
  logic [CNT_W-1:0] cnt, result, mux_cnt;
  logic             sat, missed;
  logic [7:0]       status, stat_now, mux_stat, frame_byte;
  logic [2:0]       idx, mux_idx;

  assign rise = s_q & ~s_prev;
  assign busy = (state != IDLE);

  tdc_sat_counter #(.WIDTH(CNT_W)) u_cnt (
    .clk   (clk),
    .reset (reset),
    .load1 (state == IDLE && rise),
    .en    (state == COUNT && s_q),
    .count (cnt),
    .sat   (sat)
  );

  always_comb begin
    next = state;
    case (state)
      IDLE:     if (rise) next = COUNT;
      COUNT:    if (!s_q) next = LATCH;
      LATCH:    next = SEND;
      SEND:     next = GUARD1;
      GUARD1:   next = GUARD2;
      GUARD2:   next = WAIT_EOT;
      WAIT_EOT: if (tx_eot) next = (idx == 3'(FRAME_N - 1)) ? IDLE : SEND;
      default:  next = IDLE;
    endcase
  end

  // tx_data is loaded on entry to SEND so it is already valid in the strobe cycle;
  // from LATCH the mux must look at the not-yet-latched count and flags.
  always_comb begin
    stat_now              = '0;
    stat_now[STAT_SAT]    = sat;
    stat_now[STAT_MISSED] = missed;
    mux_idx    = (state == LATCH) ? 3'd0 : idx + 3'd1;
    mux_stat   = (state == LATCH) ? stat_now : status;
    mux_cnt    = (state == LATCH) ? cnt : result;
    frame_byte = 8'h00;
    if (SEND_HEADER && mux_idx == 3'd0) frame_byte = HEADER;
    else if (mux_idx == 3'(HDR)) frame_byte = mux_stat;
    else
      for (int j = 0; j < NBYTES; j++)
        if (mux_idx == 3'(HDR + 1 + j)) frame_byte = mux_cnt[CNT_W-1-8*j -: 8];
  end

  // Synchroniser resets high so a stop held across reset needs a fresh edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b1;
      s_q    <= 1'b1;
      s_prev <= 1'b1;
    end else begin
      sync1  <= stop;
      s_q    <= sync1;
      s_prev <= s_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      tx_data    <= '0;
      tx_stt     <= 1'b0;
      overflow   <= 1'b0;
      last_count <= '0;
      result     <= '0;
      status     <= '0;
      missed     <= 1'b0;
      idx        <= '0;
    end else begin
      state  <= next;
      tx_stt <= (next == SEND);
      if (next == SEND) tx_data <= frame_byte;

      if (state == LATCH) begin
        result     <= cnt;
        last_count <= cnt;
        overflow   <= sat;
        status     <= stat_now;
        idx        <= '0;
      end else if (state == WAIT_EOT && tx_eot) begin
        idx <= idx + 3'd1;
      end

      if (rise && state != IDLE && state != COUNT) missed <= 1'b1;
      else if (state == LATCH) missed <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tdc_pulse_meter.sv
// Self-checking bench: two meters (16-bit with header, 8-bit without) fed the same stop input.
module tb_tdc_pulse_meter;

  typedef logic [7:0] bq_t[$];

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stop = 1'b0;
  logic        eot1 = 1'b0, eot2 = 1'b0;
  logic [7:0]  tx_data1, tx_data2;
  logic        tx_stt1, tx_stt2, busy1, busy2, ovf1, ovf2;
  logic [15:0] last1;
  logic [7:0]  last2;

  int n_chk = 0, n_fail = 0, cyc = 0;
  bit eot_tie = 1'b0;
  int eot_dly = 10;
  bq_t q1, q2, exp1, exp2;
  int  st1[$];

  tdc_pulse_meter #(.CNT_W(16), .SEND_HEADER(1'b1), .HEADER(8'hA5)) dut1 (
    .clk(clk), .reset(reset), .stop(stop), .tx_data(tx_data1), .tx_stt(tx_stt1),
    .tx_eot(eot1), .busy(busy1), .overflow(ovf1), .last_count(last1));

  tdc_pulse_meter #(.CNT_W(8), .SEND_HEADER(1'b0), .HEADER(8'hA5)) dut2 (
    .clk(clk), .reset(reset), .stop(stop), .tx_data(tx_data2), .tx_stt(tx_stt2),
    .tx_eot(eot2), .busy(busy2), .overflow(ovf2), .last_count(last2));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Byte collector
  initial forever begin
    @(negedge clk);
    if (tx_stt1) begin q1.push_back(tx_data1); st1.push_back(cyc); end
    if (tx_stt2) q2.push_back(tx_data2);
  end

  // Transmitter models: eot rises eot_dly cycles after a strobe and stays high (stale)
  initial begin
    int c1 = 0;
    forever begin
      @(posedge clk); #1;
      if (eot_tie) eot1 = 1'b1;
      else if (tx_stt1) begin eot1 = 1'b0; c1 = eot_dly; end
      else if (c1 > 0) begin c1--; if (c1 == 0) eot1 = 1'b1; end
    end
  end
  initial begin
    int c2 = 0;
    forever begin
      @(posedge clk); #1;
      if (eot_tie) eot2 = 1'b1;
      else if (tx_stt2) begin eot2 = 1'b0; c2 = eot_dly; end
      else if (c2 > 0) begin c2--; if (c2 == 0) eot2 = 1'b1; end
    end
  end

  // Reference: count is the pulse length clipped to all-ones; sat once all-ones is reached.
  function automatic bq_t model_frame(input int n, input bit missed, input int w, input bit hdr);
    bq_t q;
    longint maxv = (longint'(1) << w) - 1;
    longint c = (n >= maxv) ? maxv : longint'(n);
    bit sat = (n >= maxv);
    q = {};
    if (hdr) q.push_back(8'hA5);
    q.push_back({6'b0, missed, sat});
    for (int j = w / 8 - 1; j >= 0; j--) q.push_back(8'(c >> (8 * j)));
    return q;
  endfunction

  task automatic run_pulse(input int n);
    @(posedge clk); #1 stop = 1'b1;
    repeat (n) @(posedge clk);
    #1 stop = 1'b0;
  endtask

  task automatic wait_idle(output bit ok);
    repeat (4) @(posedge clk);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!busy1 && !busy2) begin ok = 1'b1; break; end
    end
  endtask

  task automatic clear_q();
    q1 = {}; q2 = {}; st1 = {};
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if (tx_data1 !== 8'h00) begin n_fail++; $display("FAIL reset tx_data got %h want 00", tx_data1); end
    n_chk++; if (tx_stt1 !== 1'b0) begin n_fail++; $display("FAIL reset tx_stt got %b want 0", tx_stt1); end
    n_chk++; if (busy1 !== 1'b0) begin n_fail++; $display("FAIL reset busy got %b want 0", busy1); end
    n_chk++; if (ovf1 !== 1'b0) begin n_fail++; $display("FAIL reset overflow got %b want 0", ovf1); end
    n_chk++; if (last1 !== 16'h0) begin n_fail++; $display("FAIL reset last_count got %h want 0", last1); end
    @(posedge clk); #1 reset = 1'b0;
    repeat (5) @(posedge clk);
  endtask

  task automatic test_pulse(input string name, input int n, input bit missed);
    bit ok;
    clear_q();
    run_pulse(n);
    wait_idle(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL %s idle timeout busy=%b/%b want 0/0", name, busy1, busy2); end
    exp1 = model_frame(n, missed, 16, 1'b1);
    n_chk++; if (q1.size() != exp1.size()) begin n_fail++; $display("FAIL %s frame length got %0d want %0d", name, q1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
      n_chk++; if (q1[i] !== exp1[i]) begin n_fail++; $display("FAIL %s byte%0d got %h want %h", name, i, q1[i], exp1[i]); end
    end
    n_chk++; if (last1 !== 16'(n >= 65535 ? 65535 : n)) begin n_fail++; $display("FAIL %s last_count got %0d want %0d", name, last1, (n >= 65535 ? 65535 : n)); end
    n_chk++; if (ovf1 !== (n >= 65535)) begin n_fail++; $display("FAIL %s overflow got %b want %b", name, ovf1, (n >= 65535)); end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_basic();
    test_pulse("basic300", 300, 1'b0);
    test_pulse("short1", 1, 1'b0);
  endtask

  task automatic test_overflow();
    test_pulse("overflow70000", 70000, 1'b0);
  endtask

  task automatic test_missed();
    bit ok;
    clear_q();
    run_pulse(20);
    ok = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (q1.size() >= 1) begin ok = 1'b1; break; end
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL missed first strobe timeout got %0d bytes want 1", q1.size()); end
    run_pulse(3);
    wait_idle(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL missed idle timeout busy=%b want 0", busy1); end
    exp1 = model_frame(20, 1'b0, 16, 1'b1);
    n_chk++; if (q1.size() != exp1.size()) begin n_fail++; $display("FAIL missed frame1 length got %0d want %0d", q1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
      n_chk++; if (q1[i] !== exp1[i]) begin n_fail++; $display("FAIL missed frame1 byte%0d got %h want %h", i, q1[i], exp1[i]); end
    end
    repeat (30) @(negedge clk);
    n_chk++; if (busy1 !== 1'b0 || q1.size() != exp1.size()) begin
      n_fail++; $display("FAIL missed no-remeasure busy=%b bytes=%0d want 0/%0d", busy1, q1.size(), exp1.size());
    end
    test_pulse("missed_next5", 5, 1'b1);
  endtask

  task automatic test_eot_tied();
    bit ok;
    eot_tie = 1'b1;
    clear_q();
    run_pulse(9);
    wait_idle(ok);
    eot_tie = 1'b0;
    n_chk++; if (!ok) begin n_fail++; $display("FAIL eot_tied idle timeout busy=%b want 0", busy1); end
    exp1 = model_frame(9, 1'b0, 16, 1'b1);
    n_chk++; if (q1.size() != 4) begin n_fail++; $display("FAIL eot_tied strobes got %0d want 4", q1.size()); end
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
      n_chk++; if (q1[i] !== exp1[i]) begin n_fail++; $display("FAIL eot_tied byte%0d got %h want %h", i, q1[i], exp1[i]); end
    end
    for (int i = 1; i < st1.size(); i++) begin
      n_chk++; if (st1[i] - st1[i-1] != 4) begin n_fail++; $display("FAIL eot_tied spacing%0d got %0d want 4", i, st1[i] - st1[i-1]); end
    end
    repeat (5) @(posedge clk);
  endtask

  task automatic test_random();
    for (int k = 0; k < 6; k++) begin
      eot_dly = int'($urandom_range(1, 20));
      test_pulse("random", int'($urandom_range(1, 800)), 1'b0);
    end
    eot_dly = 10;
  endtask

  task automatic test_reset_midframe();
    bit ok;
    clear_q();
    run_pulse(300);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (q1.size() >= 2) begin ok = 1'b1; break; end
    end
    n_chk++; if (!ok) begin n_fail++; $display("FAIL midreset 2nd byte timeout got %0d bytes want 2", q1.size()); end
    @(posedge clk); #1 stop = 1'b1; reset = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_chk++; if ({tx_data1, tx_stt1, busy1, ovf1} !== 11'h0 || last1 !== 16'h0) begin
      n_fail++; $display("FAIL midreset outputs got data=%h stt=%b busy=%b ovf=%b last=%h want all 0", tx_data1, tx_stt1, busy1, ovf1, last1);
    end
    @(posedge clk); #1 reset = 1'b0;
    clear_q();
    repeat (20) @(negedge clk);
    n_chk++; if (q1.size() != 0 || busy1 !== 1'b0 || busy2 !== 1'b0) begin
      n_fail++; $display("FAIL midreset stop-held got bytes=%0d busy=%b/%b want 0 0/0", q1.size(), busy1, busy2);
    end
    #1 stop = 1'b0;
    repeat (5) @(posedge clk);
    clear_q();
    run_pulse(7);
    wait_idle(ok);
    n_chk++; if (!ok) begin n_fail++; $display("FAIL midreset idle timeout busy=%b/%b want 0/0", busy1, busy2); end
    exp1 = model_frame(7, 1'b0, 16, 1'b1);
    exp2 = model_frame(7, 1'b0, 8, 1'b0);
    n_chk++; if (q1.size() != exp1.size()) begin n_fail++; $display("FAIL midreset w16 length got %0d want %0d", q1.size(), exp1.size()); end
    for (int i = 0; i < exp1.size() && i < q1.size(); i++) begin
      n_chk++; if (q1[i] !== exp1[i]) begin n_fail++; $display("FAIL midreset w16 byte%0d got %h want %h", i, q1[i], exp1[i]); end
    end
    n_chk++; if (q2.size() != exp2.size()) begin n_fail++; $display("FAIL midreset w8 length got %0d want %0d", q2.size(), exp2.size()); end
    for (int i = 0; i < exp2.size() && i < q2.size(); i++) begin
      n_chk++; if (q2[i] !== exp2[i]) begin n_fail++; $display("FAIL midreset w8 byte%0d got %h want %h", i, q2[i], exp2[i]); end
    end
    n_chk++; if (last2 !== 8'd7) begin n_fail++; $display("FAIL midreset w8 last_count got %0d want 7", last2); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_missed();
    test_eot_tied();
    test_random();
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
